// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin sharing of one byte UART transmitter between two 16-bit word requesters
module uart_tx_scheduler #(
    parameter logic [2:0] DEFAULT_BAUD = 3'd7,
    parameter int         GAP_CYCLES   = 16,
    parameter int         ACK_TIMEOUT  = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [15:0] data0,
    input  logic [15:0] data1,
    input  logic [2:0]  baud0,
    input  logic [2:0]  baud1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [7:0]  tx_data,
    output logic        tx_wr,
    input  logic        tx_busy,
    output logic [2:0]  baud_select,
    output logic        busy,
    output logic        retry_err
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] LOAD      = 3'd1;
    localparam logic [2:0] WAIT_ACK  = 3'd2;
    localparam logic [2:0] WAIT_DONE = 3'd3;
    localparam logic [2:0] GAP       = 3'd4;
    localparam int CW = $clog2(GAP_CYCLES > ACK_TIMEOUT ? GAP_CYCLES : ACK_TIMEOUT) + 1;
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] ACK_LAST = CW'(ACK_TIMEOUT - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);

    logic [2:0]    state;
    logic [15:0]   word;
    logic          id;
    logic          last;
    logic          win;
    logic [1:0]    k;
    logic [CW-1:0] cnt;
    logic [3:0]    nib;

    // on a tie the requester not served last wins
    assign win  = (req0 && req1) ? ~last : req1;
    assign nib  = word[{k, 2'b00} +: 4];
    assign busy = state != IDLE;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            word        <= 16'h0000;
            id          <= 1'b0;
            last        <= 1'b1;
            k           <= 2'd3;
            cnt         <= '0;
            tx_wr       <= 1'b0;
            tx_data     <= 8'h00;
            baud_select <= DEFAULT_BAUD;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            done0       <= 1'b0;
            done1       <= 1'b0;
            retry_err   <= 1'b0;
        end else begin
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            tx_wr <= 1'b0;
            case (state)
                IDLE: if (req0 || req1) begin
                    id          <= win;
                    word        <= win ? data1 : data0;
                    baud_select <= win ? baud1 : baud0;
                    gnt0        <= ~win;
                    gnt1        <= win;
                    k           <= 2'd3;
                    state       <= LOAD;
                end
                LOAD: begin
                    tx_wr   <= 1'b1;
                    tx_data <= {id, 1'b0, k, nib};
                    cnt     <= '0;
                    state   <= WAIT_ACK;
                end
                // a busy level only counts as an ack once the strobe has been issued
                WAIT_ACK: if (tx_busy) begin
                    state <= WAIT_DONE;
                end else if (cnt == ACK_LAST) begin
                    retry_err <= 1'b1;
                    state     <= LOAD;
                end else begin
                    cnt <= cnt + ONE;
                end
                WAIT_DONE: if (!tx_busy) begin
                    if (k != 2'd0) begin
                        k     <= k - 2'd1;
                        state <= LOAD;
                    end else begin
                        done0 <= ~id;
                        done1 <= id;
                        last  <= id;
                        cnt   <= '0;
                        state <= GAP;
                    end
                end
                GAP: if (cnt == GAP_LAST) state <= IDLE; else cnt <= cnt + ONE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Round-robin scheduler sharing one byte-level UART transmitter between two 16-bit word requesters. Each granted word is sent as four framed nibble bytes, most significant nibble first, paced by the transmitter's write/busy handshake. The block also drives the transmitter's `baud_select`, switching it only between words. It sits between the word sources (display/data producers) and the UART transmitter channel.

## Interface
Parameters:
- `DEFAULT_BAUD`, 3'd7: `baud_select` value out of reset.
- `GAP_CYCLES`, 16: idle clocks enforced after each word before the next grant (≥1).
- `ACK_TIMEOUT`, 64: clocks waited in WAIT_ACK before a byte is retried (≥2).

Ports:
- `clk`, in, 1: single clock, all logic on the rising edge.
- `reset`, in, 1: synchronous, active-low.
- `req0`, `req1`, in, 1: level requests; hold with data/baud stable until the matching `gnt`.
- `data0`, `data1`, in, 16: word to send.
- `baud0`, `baud1`, in, 3: baud code for that requester's word.
- `gnt0`, `gnt1`, out, 1: one-cycle pulse; the word was latched on this edge.
- `done0`, `done1`, out, 1: one-cycle pulse after the fourth byte completes.
- `tx_data`, out, 8: byte to the transmitter.
- `tx_wr`, out, 1: one-cycle write strobe.
- `tx_busy`, in, 1: transmitter busy.
- `baud_select`, out, 3: transmitter baud code.
- `busy`, out, 1: high whenever state ≠ IDLE.
- `retry_err`, out, 1: sticky, set on any ACK timeout, cleared only by reset.

## Operation
- States: IDLE, LOAD, WAIT_ACK, WAIT_DONE, GAP.
- IDLE: if any req is high, pick a winner and latch `data`, `baud`, and id. Drive the matching `gnt` high for the next cycle, update `baud_select`, clear byte index k to 3, and go to LOAD.
- Arbitration: with one request, that requester wins. With both, the requester not served last wins. The last-served pointer resets to 1, so `req0` wins the first tie.
- Frame byte: `tx_data` = {id, 1'b0, k[1:0], word[4k+3:4k]}. Byte order is k = 3, 2, 1, 0.
- LOAD: `tx_wr`=1 for exactly one cycle with `tx_data` valid. Clear the timeout counter and go to WAIT_ACK.
- WAIT_ACK: wait for `tx_busy`=1, then go to WAIT_DONE. If `ACK_TIMEOUT` clocks pass without `tx_busy`, set `retry_err` and return to LOAD with the same byte.
- WAIT_DONE: wait for `tx_busy`=0.
  - If k > 0: decrement k and go to LOAD.
  - If k = 0: pulse the matching `done`, update the last-served pointer, and go to GAP.
- GAP: count `GAP_CYCLES` clocks, then go to IDLE.
- A `req` still high after `done` is a new request for the same data.
- `req` and `data` changes are ignored outside IDLE.
- `baud_select` changes only on the grant edge and is constant for the whole word and gap.
- `tx_busy` already high in LOAD is not an ack; only a high `tx_busy` sampled in WAIT_ACK counts.

## Timing
- Reset values: `tx_wr`=0, `tx_data`=8'h00, `baud_select`=`DEFAULT_BAUD`, `gnt*`=0, `done*`=0, `busy`=0, `retry_err`=0, state IDLE, last-served=1.
- Reset asserted mid-word aborts at the next edge: no `done`, no further `tx_wr`, and all outputs take their reset values.
- Edge E samples `req` in IDLE. On edge E+1, `gnt` is high and `baud_select` updates. On edge E+2, `tx_wr` is high, because LOAD is the cycle after the grant.
- With a transmitter raising `tx_busy` 1 cycle after `tx_wr` and holding it for B cycles, each byte takes 3+B clocks from LOAD entry to the next LOAD.
- `done` occurs 1 clock after the last `tx_busy` fall is sampled.
- A new grant is possible no earlier than `GAP_CYCLES`+1 clocks after `done`.
- `gnt`, `done`, and `tx_wr` are never high for two consecutive cycles.
- Exactly one `tx_wr` is issued per byte attempt.

## Test plan
- **Single word:** reset, then `req0`=1, `data0`=16'hCC10, `baud0`=3'd7, with a transmitter model where B=10. Expect `gnt0` pulse, `tx_data` 0x3C, 0x2C, 0x11, 0x00 in order, 4 `tx_wr` pulses, 1 `done0`, and `baud_select`=7 throughout.
- **Tie and round-robin:** `req0` and `req1` asserted on the same cycle, `data1`=16'h0001. Expect `req0` served first. Then `req1` is sent as 0xB0, 0xA0, 0x90, 0x81. With both requests held, the grant order continues 0, 1, 0, 1.
- **Baud switch:** `baud0`=3'd2, `baud1`=3'd5 served back-to-back. Expect `baud_select` to change only on `gnt` edges and never between `tx_wr` pulses of one word.
- **Ack timeout:** the transmitter ignores the first `tx_wr`. Expect a second `tx_wr` with the same byte exactly `ACK_TIMEOUT`+1 clocks later, and `retry_err` to go high and stay high.
- **Mid-word reset:** assert `reset`=0 during WAIT_DONE of byte k=1. Expect all outputs at reset values the next cycle and no `done`. After release, a pending `req1` is granted and `req0` wins a subsequent tie.
- **Gap enforcement:** hold `req0` permanently. Expect exactly `GAP_CYCLES`+1 clocks between `done0` and the next `gnt0`.
